// File: rtl/demux_event_counter_if.sv
// Readout port of demux_event_counter: request/response with a held response.
// master = the consumer that reads counts, slave = the counter block.
interface demux_event_counter_if #(
  parameter int WIDTH = 8
);
  logic             rd_req;
  logic [2:0]       rd_sel;
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ovf;
  logic             rd_busy;

  modport master (
    output rd_req, rd_sel, rd_ready,
    input  rd_valid, rd_data, rd_ovf, rd_busy
  );

  modport slave (
    input  rd_req, rd_sel, rd_ready,
    output rd_valid, rd_data, rd_ovf, rd_busy
  );
endinterface

// File: rtl/demux_event_counter.sv
// Per-channel rising-edge counters for the eight 1-to-8 demux outputs,
// read out one channel at a time with clear-on-read.
module demux_event_counter #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a,
  input  logic                   b,
  input  logic                   c,
  input  logic                   d,
  input  logic                   e,
  input  logic                   f,
  input  logic                   g,
  input  logic                   h,
  input  logic                   en,
  demux_event_counter_if.slave   rd
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_prev;
  logic [WIDTH-1:0] r_count [8];
  logic [7:0]       r_ovf;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_ovf;

  logic [7:0]       w_in;
  logic [7:0]       w_evt;
  logic             w_capture;

  assign w_in      = {h, g, f, e, d, c, b, a};
  assign w_evt     = w_in & ~r_prev & {8{en}};
  assign w_capture = (r_state == IDLE) && rd.rd_req;

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (rd.rd_req)   w_next_state = RESP;
      RESP: if (rd.rd_ready) w_next_state = IDLE;
      default:               w_next_state = IDLE;
    endcase
  end

  always_comb begin
    rd.rd_valid = 1'b0;
    rd.rd_busy  = 1'b0;
    if (r_state == RESP) begin
      rd.rd_valid = 1'b1;
      rd.rd_busy  = 1'b1;
    end
  end

  // Edge history tracks the inputs even while counting is disabled, so a
  // level that rose during en=0 is not counted when en returns high.
  always_ff @(posedge clk) begin
    if (rst) r_prev <= '0;
    else     r_prev <= w_in;
  end

  // NOTE: the counter array is only eight words of flops, so it is reset
  // like ordinary registers rather than treated as an unreset memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_count[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_capture && (rd.rd_sel == 3'(i))) begin
          // A same-cycle event survives the clear instead of being lost.
          r_count[i] <= w_evt[i] ? WIDTH'(1) : '0;
          r_ovf[i]   <= 1'b0;
        end else if (w_evt[i]) begin
          if (r_count[i] == COUNT_MAX) r_ovf[i]   <= 1'b1;
          else                         r_count[i] <= r_count[i] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
      r_rd_ovf  <= 1'b0;
    end else if (w_capture) begin
      r_rd_data <= r_count[rd.rd_sel];
      r_rd_ovf  <= r_ovf[rd.rd_sel];
    end
  end

  assign rd.rd_data = r_rd_data;
  assign rd.rd_ovf  = r_rd_ovf;

endmodule

// File: doc/demux_event_counter.md
Name: demux_event_counter

Overview:
- Sits directly downstream of the 1-to-8 demultiplexer and consumes its eight one-hot outputs a..h.
- Keeps a per-channel count of rising edges (events) routed to each demux output.
- Exposes the counts through a single request/response readout port with clear-on-read.
- Used to verify routing distribution and as a per-channel activity monitor.

Parameters:
- WIDTH, 8, bit width of each channel counter and of rd_data; legal range 2..16.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  demux channel 0 output.
- b  input  1  demux channel 1 output.
- c  input  1  demux channel 2 output.
- d  input  1  demux channel 3 output.
- e  input  1  demux channel 4 output.
- f  input  1  demux channel 5 output.
- g  input  1  demux channel 6 output.
- h  input  1  demux channel 7 output.
- en  input  1  count enable; edges are ignored while low.
- rd_req  input  1  read request, sampled only in IDLE.
- rd_sel  input  3  channel to read (0=a .. 7=h), sampled with rd_req.
- rd_ready  input  1  consumer accepts the response.
- rd_valid  output  1  response valid.
- rd_data  output  WIDTH  snapshot of the selected counter.
- rd_ovf  output  1  snapshot of the selected channel's sticky overflow flag.
- rd_busy  output  1  high while in RESP; rd_req is ignored.

Behaviour:
- Reset: synchronous, active-high, one clock and one reset, no asynchronous paths. Reset has priority over all other activity.
- Reset values: all counters 0, all ovf flags 0, edge-history registers 0, state IDLE, rd_valid 0, rd_data 0, rd_ovf 0, rd_busy 0.
- Edge detect:
  - Per channel, prev_i <= in_i every cycle, including when en=0.
  - An event is in_i=1 and prev_i=0.
  - prev resets to 0, so an input already high in the first cycle after reset counts as one event (if en=1).
  - A held-high input counts once.
- Counting:
  - On an event with en=1, count_i increments by 1.
  - Saturating: at 2^WIDTH-1 the count holds, and ovf_i sets (sticky) on each further event.
  - Several channels may count in the same cycle. Correct upstream drive is one-hot, but the block does not assume it.
- FSM has two states, IDLE and RESP.
  - IDLE, rd_req=1: on this clock edge, capture rd_data <= count[rd_sel] and rd_ovf <= ovf[rd_sel]. Clear count[rd_sel] and ovf[rd_sel]. Go to RESP with rd_valid=1 next cycle. Latency is 1 cycle.
  - Clear vs. same-cycle event: if an event hits the selected channel in the same cycle as the clear, the counter becomes 1 (not 0) and is not lost. The snapshot excludes that event.
  - RESP: rd_valid=1, rd_busy=1. rd_data and rd_ovf are held stable. rd_req and rd_sel are ignored. Counting continues on all channels.
  - RESP, rd_ready=1: return to IDLE; rd_valid=0 the next cycle. A new rd_req is accepted no earlier than the cycle after return to IDLE, so there is at most one response per 2 cycles.
  - rd_ready while in IDLE has no effect.
- Reset mid-response: rd_valid drops to 0 the cycle after rst; the pending response is discarded.
- en=0: counters and flags hold. Reads and clears still operate.
- rd_data keeps its last value in IDLE; it is don't-care when rd_valid=0.

Test Plan:
- Reset, then pulse a 3 times (1-cycle highs separated by lows), en=1; rd_req with rd_sel=0 -> next cycle rd_valid=1, rd_data=3, rd_ovf=0. Read again -> rd_data=0.
- Hold c high for 10 cycles -> a read of sel=2 returns 1. Drive e high in the first cycle after reset -> a read of sel=4 returns 1.
- WIDTH=8: send 257 events on h -> rd_data=255, rd_ovf=1. Immediate re-read -> rd_data=0, rd_ovf=0.
- Read sel=1 in the same cycle as an event on b (prior count 5) -> rd_data=5. Next read -> rd_data=1.
- Hold rd_ready=0 for 4 cycles with rd_req toggling -> rd_valid stays 1, rd_data stable, rd_busy=1, no second capture. rd_ready=1 -> rd_valid=0 the next cycle.
- en=0 with 4 events on d, then en=1 with 2 events -> read returns 2. Assert rst while rd_valid=1 -> rd_valid=0 the next cycle and all reads return 0.
